// File: rtl/sysid_pkg.sv
// sysid_pkg -- shared constants and types for the system ID / uptime slave.
//   Word-address map, CTRL bit indices, data width and NUM_USER bound,
//   plus the request struct the top level uses to bundle one bus beat.
package sysid_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 4;
  localparam int MAX_USER = 8;

  typedef logic [ADDR_W-1:0] addr_t;

  localparam addr_t ADDR_ID        = 4'd0;
  localparam addr_t ADDR_TIMESTAMP = 4'd1;
  localparam addr_t ADDR_SCRATCH   = 4'd2;
  localparam addr_t ADDR_CTRL      = 4'd3;
  localparam addr_t ADDR_UPTIME_LO = 4'd4;
  localparam addr_t ADDR_UPTIME_HI = 4'd5;
  localparam addr_t ADDR_USER0     = 4'd6;

  localparam int CTRL_CLEAR  = 0;
  localparam int CTRL_FREEZE = 1;

  // One bus beat as seen by the slave in a single cycle.
  typedef struct packed {
    logic              rd;
    logic              wr;
    addr_t             addr;
    logic [DATA_W-1:0] wdata;
  } sysid_req_t;

endpackage

// File: rtl/system_qsys_sysid_mm_if.sv
// system_qsys_sysid_mm_if -- Avalon-MM word bus between a master and the
// sysid slave.
//   address[3:0], read, write, writedata[31:0] : master -> slave
//   readdata[31:0], readdatavalid               : slave -> master
interface system_qsys_sysid_mm_if;

  logic [3:0]  address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        readdatavalid;

  modport master (
    output address, read, write, writedata,
    input  readdata, readdatavalid
  );

  modport slave (
    input  address, read, write, writedata,
    output readdata, readdatavalid
  );

endinterface

// File: rtl/sysid_uptime.sv
// sysid_uptime -- 64-bit free-running uptime counter with CLEAR/FREEZE
// control and a high-word snapshot taken on every UPTIME_LO read.
// Only built when SYSID_UPTIME_EN is defined.
//   clock, reset   : rising-edge clock, synchronous active-high reset
//   ctrl_we        : CTRL word write this cycle
//   ctrl_clear     : writedata CLEAR bit (pulse, never stored)
//   ctrl_freeze    : writedata FREEZE bit (stored)
//   lo_rd          : UPTIME_LO read this cycle -> latch high word
//   ctrl_rd        : CTRL read view (CLEAR always reads 0)
//   up_lo          : live low word
//   snap_hi        : snapshot of the high word
`ifdef SYSID_UPTIME_EN
module sysid_uptime
  import sysid_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              ctrl_we,
  input  logic              ctrl_clear,
  input  logic              ctrl_freeze,
  input  logic              lo_rd,
  output logic [DATA_W-1:0] ctrl_rd,
  output logic [DATA_W-1:0] up_lo,
  output logic [DATA_W-1:0] snap_hi
);

  logic [63:0]       cnt_q;
  logic              freeze_q;
  logic [DATA_W-1:0] snap_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q    <= '0;
      freeze_q <= 1'b0;
      snap_q   <= '0;
    end else begin
      // Snapshot pairs with the low word returned by the same read.
      if (lo_rd) snap_q <= cnt_q[63:32];
      if (ctrl_we) freeze_q <= ctrl_freeze;
      // CLEAR beats both FREEZE and increment; FREEZE acts from the
      // cycle after it is written.
      if (ctrl_we && ctrl_clear) cnt_q <= '0;
      else if (!freeze_q)        cnt_q <= cnt_q + 64'd1;
    end
  end

  always_comb begin
    ctrl_rd              = '0;
    ctrl_rd[CTRL_FREEZE] = freeze_q;
  end

  assign up_lo   = cnt_q[31:0];
  assign snap_hi = snap_q;

endmodule
`endif

// File: rtl/system_qsys_sysid_mm.sv
// system_qsys_sysid_mm -- Avalon-MM system ID slave.
//   Word map: 0 ID, 1 TIMESTAMP, 2 SCRATCH (RW), 3 CTRL (RW), 4 UPTIME_LO,
//   5 UPTIME_HI (snapshot), 6..5+NUM_USER user_id words; all else reads 0.
//   Fixed read latency of one cycle; readdata holds between responses.
//   Optional feature macro: SYSID_UPTIME_EN builds the uptime counter and
//   words 3..5; without it those addresses behave as unmapped.
// Ports:
//   clock, reset : rising-edge clock, synchronous active-high reset
//   bus          : system_qsys_sysid_mm_if.slave
//   user_id      : NUM_USER static words, word k at [32k+31:32k]
// NUM_USER must lie in 1..MAX_USER so the user words fit the 4-bit map.
module system_qsys_sysid_mm
  import sysid_pkg::*;
#(
  parameter logic [DATA_W-1:0] ID_VALUE  = 32'h5CA2_6A29,
  parameter logic [DATA_W-1:0] TIMESTAMP = 32'h0,
  parameter int                NUM_USER  = 2
) (
  input  logic                             clock,
  input  logic                             reset,
  system_qsys_sysid_mm_if.slave            bus,
  input  logic [NUM_USER-1:0][DATA_W-1:0]  user_id
);

  localparam int STAGES = 0;

  sysid_req_t        req;
  logic [DATA_W-1:0] scratch_q;
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] rd_mux;
  logic [STAGES:0]   vld_pipe;

  assign req = '{rd: bus.read, wr: bus.write, addr: bus.address,
                 wdata: bus.writedata};

`ifdef SYSID_UPTIME_EN
  logic [DATA_W-1:0] ctrl_rd, up_lo, snap_hi;

  sysid_uptime u_up (
    .clock       (clock),
    .reset       (reset),
    .ctrl_we     (req.wr && req.addr == ADDR_CTRL),
    .ctrl_clear  (req.wdata[CTRL_CLEAR]),
    .ctrl_freeze (req.wdata[CTRL_FREEZE]),
    .lo_rd       (req.rd && req.addr == ADDR_UPTIME_LO),
    .ctrl_rd     (ctrl_rd),
    .up_lo       (up_lo),
    .snap_hi     (snap_hi)
  );
`endif

  // Read mux sees pre-edge state, so a same-cycle write is not visible.
  always_comb begin
    rd_mux = '0;
    case (req.addr)
      ADDR_ID:        rd_mux = ID_VALUE;
      ADDR_TIMESTAMP: rd_mux = TIMESTAMP;
      ADDR_SCRATCH:   rd_mux = scratch_q;
`ifdef SYSID_UPTIME_EN
      ADDR_CTRL:      rd_mux = ctrl_rd;
      ADDR_UPTIME_LO: rd_mux = up_lo;
      ADDR_UPTIME_HI: rd_mux = snap_hi;
`endif
      default: begin
        for (int k = 0; k < NUM_USER; k++)
          if (req.addr == 4'(ADDR_USER0 + k)) rd_mux = user_id[k];
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      scratch_q <= '0;
      rdata_q   <= '0;
      vld_pipe  <= '0;
    end else begin
      if (req.wr && req.addr == ADDR_SCRATCH) scratch_q <= req.wdata;
      if (req.rd) rdata_q <= rd_mux;
      vld_pipe[0] <= req.rd;
      for (int i = 1; i <= STAGES; i++) vld_pipe[i] <= vld_pipe[i-1];
    end
  end

  assign bus.readdata = rdata_q;
  // A reset arriving while a response is on the bus drops it immediately.
  assign bus.readdatavalid = vld_pipe[STAGES] & ~reset;

endmodule

// File: tb/tb_system_qsys_sysid_mm.sv
// tb_system_qsys_sysid_mm -- directed + random bench with a word-level
// reference model of the register map (scratch, CTRL freeze, 64-bit uptime,
// snapshot, last read data). Build with +define+SYSID_UPTIME_EN to cover
// the uptime words; without it addresses 3..5 are expected to read 0.
module tb_system_qsys_sysid_mm;

  localparam int          NU = 3;
  localparam logic [31:0] ID = 32'h5CA2_6A29;
  localparam logic [31:0] TS = 32'h6512_0A0B;
`ifdef SYSID_UPTIME_EN
  localparam bit UP_EN = 1'b1;
`else
  localparam bit UP_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic [NU-1:0][31:0] user_id;
  always #5 clk = ~clk;

  system_qsys_sysid_mm_if bus ();

  system_qsys_sysid_mm #(.TIMESTAMP(TS), .NUM_USER(NU)) dut (
    .clock   (clk),
    .reset   (reset),
    .bus     (bus.slave),
    .user_id (user_id)
  );

  int n_asrt = 0;
  int n_fail = 0;

  // reference model state
  logic [31:0] m_scratch, m_snap, m_rdata;
  logic        m_freeze;
  logic [63:0] m_up;

  function automatic logic [31:0] m_read(input logic [3:0] a);
    int ai = int'(a);
    if (ai == 0) return ID;
    if (ai == 1) return TS;
    if (ai == 2) return m_scratch;
    if (UP_EN && ai == 3) return {30'b0, m_freeze, 1'b0};
    if (UP_EN && ai == 4) return m_up[31:0];
    if (UP_EN && ai == 5) return m_snap;
    if (ai >= 6 && ai < 6 + NU) return user_id[ai-6];
    return 32'h0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One bus cycle: drive, clock, advance the model, check after the edge.
  task automatic cyc(input bit rd, input bit wr, input logic [3:0] a, input logic [31:0] wd);
    logic [31:0] exp;
    logic [63:0] nxt;
    bit clr;
    bus.read = rd; bus.write = wr; bus.address = a; bus.writedata = wd;
    exp = m_read(a);
    @(posedge clk);
    if (reset) begin
      m_scratch = 0; m_freeze = 0; m_up = 0; m_snap = 0; m_rdata = 0;
    end else begin
      if (rd) begin
        m_rdata = exp;
        if (UP_EN && a == 4'd4) m_snap = m_up[63:32];
      end
      clr = UP_EN && wr && a == 4'd3 && wd[0];
      nxt = clr ? 64'd0 : (m_freeze ? m_up : m_up + 64'd1);
      if (wr && a == 4'd2) m_scratch = wd;
      if (UP_EN && wr && a == 4'd3) m_freeze = wd[1];
      m_up = nxt;
    end
    #1;
    bus.read = 1'b0; bus.write = 1'b0;
    chk($sformatf("rdv a=%0d", a), {31'b0, bus.readdatavalid}, {31'b0, rd && !reset});
    chk($sformatf("rdata a=%0d", a), bus.readdata, m_rdata);
  endtask

  task automatic rd(input logic [3:0] a);  cyc(1'b1, 1'b0, a, 32'h0); endtask
  task automatic wr(input logic [3:0] a, input logic [31:0] d); cyc(1'b0, 1'b1, a, d); endtask
  task automatic idle(input int n); for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 4'd0, 32'h0); endtask

`ifdef SYSID_UPTIME_EN
  task automatic set_up(input logic [63:0] v);
    force dut.u_up.cnt_q = v;
    #1;
    release dut.u_up.cnt_q;
    m_up = v;
  endtask
`endif

  initial begin
    for (int k = 0; k < NU; k++) user_id[k] = $urandom;
    bus.read = 0; bus.write = 0; bus.address = 0; bus.writedata = 0;
    m_scratch = 0; m_freeze = 0; m_up = 0; m_snap = 0; m_rdata = 0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset rdv", {31'b0, bus.readdatavalid}, 32'h0);
    chk("reset rdata", bus.readdata, 32'h0);
    reset = 1'b0;

    // ID / timestamp, single-cycle valid pulse
    rd(4'd0); rd(4'd1); idle(1);
    // scratch RW, RO write ignored, unmapped read
    wr(4'd2, 32'hDEAD_BEEF); rd(4'd2);
    wr(4'd0, 32'h0000_1234); rd(4'd0);
    rd(4'd15); idle(2);
    // same-cycle read + write returns old value
    wr(4'd2, 32'hA);
    cyc(1'b1, 1'b1, 4'd2, 32'hB);
    rd(4'd2);
    // user words and the first unmapped address past them
    rd(4'd6); rd(4'd7); rd(4'd8); rd(4'd9);
    // CTRL / uptime words (read 0 when the feature is absent)
    rd(4'd3); rd(4'd4); rd(4'd5);
    wr(4'd4, 32'hFFFF_FFFF); wr(4'd3, 32'h3);
    rd(4'd3); rd(4'd4); idle(2); rd(4'd4);
    wr(4'd3, 32'h0); idle(3); rd(4'd4); rd(4'd5); rd(4'd3);

`ifdef SYSID_UPTIME_EN
    // snapshot vs live high word across a low-word carry
    set_up(64'h0000_0000_FFFF_FFFF);
    rd(4'd4); idle(3); rd(4'd5);
    // wrap from all ones
    set_up(64'hFFFF_FFFF_FFFF_FFFF);
    rd(4'd4); rd(4'd5); rd(4'd4); rd(4'd5);
    // CLEAR while frozen still clears
    wr(4'd3, 32'h2); idle(2); wr(4'd3, 32'h3); rd(4'd4); rd(4'd3);
    wr(4'd3, 32'h1); idle(2); rd(4'd4); rd(4'd3);
`endif

    // random traffic against the model
    for (int i = 0; i < 300; i++)
      cyc(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
          4'($urandom_range(0, 15)), $urandom);

    // reset one cycle after a read drops the response
    wr(4'd2, 32'h5555_AAAA); wr(4'd3, 32'h2);
    bus.read = 1'b1; bus.address = 4'd1;
    @(posedge clk);
    bus.read = 1'b0;
    reset = 1'b1;
    #1;
    chk("drop rdv", {31'b0, bus.readdatavalid}, 32'h0);
    cyc(1'b0, 1'b0, 4'd0, 32'h0);
    cyc(1'b0, 1'b0, 4'd0, 32'h0);
    reset = 1'b0;
    rd(4'd4); rd(4'd4);
    rd(4'd2); rd(4'd3); rd(4'd5); rd(4'd6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
